serial_word_deserializer: RTL

//   Serial-in/parallel-out receiver for the rotating-register link: reassembles WIDTH-bit words

---
 rtl/serial_word_deserializer_pkg.sv | 14 +
 rtl/word_out_buffer.sv | 33 +++
 rtl/serial_word_deserializer.sv | 107 ++++++++++
 3 files changed

// File: rtl/serial_word_deserializer_pkg.sv
// Shared types and constants for the serial word deserializer.
package serial_word_deserializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic MSB_FIRST = 1'b0;
  localparam logic LSB_FIRST = 1'b1;

endpackage

// File: rtl/word_out_buffer.sv
// One-entry valid/ready holding register; a write is taken when empty or
// when the held word is draining in the same cycle, otherwise it is dropped.
module word_out_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ready,
  output logic             full,
  output logic [WIDTH-1:0] data,
  output logic             dropped
);

  logic accepted;

  assign accepted = wr_en && (!full || rd_ready);
  assign dropped  = wr_en && !accepted;

  always_ff @(posedge clk) begin
    if (reset) begin
      full <= 1'b0;
      data <= '0;
    end else if (accepted) begin
      full <= 1'b1;
      data <= wr_data;
    end else if (full && rd_ready) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/serial_word_deserializer.sv
// Reassembles WIDTH-bit words from a qualified serial stream, MSB- or
// LSB-first, and hands them to a one-entry valid/ready output buffer.
module serial_word_deserializer
  import serial_word_deserializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       lsb_first,
  input  logic                       ser_in,
  input  logic                       ser_valid,
  input  logic                       out_ready,
  input  logic                       clear_overrun,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  output logic                       busy,
  output logic [$clog2(WIDTH+1)-1:0] bit_count,
  output logic                       overrun
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  logic [CNT_W-1:0] count_reg;
  logic             order_reg;
  logic             overrun_reg;
  logic             capture;
  logic             complete;
  logic             word_dropped;

  assign capture  = (state_reg == SHIFT) && ser_valid;
  assign complete = capture && (count_reg == LAST_BIT);

  // The completing word must include the bit arriving this cycle.
  always_comb begin
    shift_next = {shift_reg[WIDTH-2:0], ser_in};
    if (order_reg == LSB_FIRST) begin
      shift_next = {ser_in, shift_reg[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      count_reg <= '0;
      order_reg <= MSB_FIRST;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= SHIFT;
            shift_reg <= '0;
            count_reg <= '0;
            order_reg <= lsb_first;
          end
        end
        SHIFT: begin
          if (capture) begin
            shift_reg <= shift_next;
            if (complete) begin
              count_reg <= '0;
              state_reg <= IDLE;
            end else begin
              count_reg <= count_reg + 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_reg <= 1'b0;
    end else if (word_dropped) begin
      overrun_reg <= 1'b1;
    end else if (clear_overrun) begin
      overrun_reg <= 1'b0;
    end
  end

  word_out_buffer #(
    .WIDTH(WIDTH)
  ) u_word_out_buffer (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (complete),
    .wr_data (shift_next),
    .rd_ready(out_ready),
    .full    (out_valid),
    .data    (out_data),
    .dropped (word_dropped)
  );

  assign busy      = (state_reg == SHIFT);
  assign bit_count = count_reg;
  assign overrun   = overrun_reg;

endmodule
